alu_serial_sequencer: RTL

Bit-serial ALU engine for the LEGv8 64-bit datapath. It drives one external 1-bit ALU slice for WIDTH consecutive cycles, feeding one operand bit pair per cycle and chaining the slice's carry-out back in. It assembles the WIDTH-bit result, including set-on-less-than, and reports flags with a start/done handshake. It is the initiator/consumer side of the slice interface (ain, bin, cin, pass, S, f, cout, set) and trades a 64-slice ripple array for one slice plus a counter.

---
 rtl/alu_serial_sequencer_if.sv | 33 +++
 rtl/alu_serial_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_serial_sequencer_if.sv
// rtl/alu_serial_sequencer_if.sv - request/response bundle for the bit-serial ALU sequencer
//
// Purpose: groups the operation request (start, op, cin0, a, b) and the
// response (busy, done, result, zero, carry, ovf) of alu_serial_sequencer.
//
// Modports:
//   master - the requester: drives start/op/cin0/a/b and observes the response
//   slave  - the sequencer: observes the request and drives the response
interface alu_serial_sequencer_if #(
  parameter int WIDTH = 64
) ();
  logic             start;
  logic [3:0]       op;
  logic             cin0;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             ovf;

  modport master (
    output start, op, cin0, a, b,
    input  busy, done, result, zero, carry, ovf
  );

  modport slave (
    input  start, op, cin0, a, b,
    output busy, done, result, zero, carry, ovf
  );
endinterface

// File: rtl/alu_serial_sequencer.sv
// rtl/alu_serial_sequencer.sv - bit-serial ALU engine driving one external 1-bit ALU slice
//
// Purpose: runs a WIDTH-bit ALU operation through a single combinational
// 1-bit slice, one bit per cycle (LSB first), chaining the slice carry-out
// back into the next bit. Assembles the result (including set-on-less-than)
// and reports a one-cycle done pulse.
//
// Build option: define ALU_SEQ_FLAGS_EN to build the zero/carry/ovf flag
// registers; without it the flags are tied to 0.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous, active-high; clears all state
//   bus         alu_serial_sequencer_if.slave: start/op/cin0/a/b in,
//               busy/done/result/zero/carry/ovf out
//   slice_a     operand A bit to the slice
//   slice_b     operand B bit to the slice
//   slice_cin   carry into the slice
//   slice_pass  pass input of the slice (always 0 here)
//   slice_s     slice select (latched op)
//   slice_f     slice result bit
//   slice_cout  slice carry-out
//   slice_set   slice raw sum bit (sign source for SLT)
module alu_serial_sequencer #(
  parameter int WIDTH = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  alu_serial_sequencer_if.slave bus,
  output logic                 slice_a,
  output logic                 slice_b,
  output logic                 slice_cin,
  output logic                 slice_pass,
  output logic [3:0]           slice_s,
  input  logic                 slice_f,
  input  logic                 slice_cout,
  input  logic                 slice_set
);

  localparam int IDXW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic             c;
  logic [IDXW-1:0]  idx;

  logic             load;
  logic             last;
  logic             slt;
  logic [WIDTH-1:0] final_res;

  // A new operation is accepted only from IDLE or DONE; start in RUN is ignored.
  always_comb begin
    load = bus.start && ((state == IDLE) || (state == DONE));
    last = (state == RUN) && (idx == LAST_IDX);
    slt  = (op_q[1:0] == 2'b11);
    // Value the result register takes at the final RUN edge. Bits below the
    // MSB are already stored; SLT replaces everything with the raw sign.
    final_res = slt ? {{(WIDTH-1){1'b0}}, slice_set}
                    : {slice_f, result_q[WIDTH-2:0]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    slice_a    = 1'b0;
    slice_b    = 1'b0;
    slice_cin  = 1'b0;
    slice_pass = 1'b0;
    slice_s    = op_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = RUN;
        end
      end
      RUN: begin
        bus.busy  = 1'b1;
        slice_a   = a_q[idx];
        slice_b   = b_q[idx];
        slice_cin = c;
        if (idx == LAST_IDX) begin
          state_n = DONE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_n  = bus.start ? RUN : IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c        <= 1'b0;
      idx      <= '0;
      result_q <= '0;
    end else if (load) begin
      op_q     <= bus.op;
      a_q      <= bus.a;
      b_q      <= bus.b;
      c        <= bus.cin0;
      idx      <= '0;
      result_q <= '0;
    end else if (state == RUN) begin
      c <= slice_cout;
      if (last) begin
        // idx parks at the MSB so it never wraps.
        result_q <= final_res;
      end else begin
        result_q[idx] <= slice_f;
        idx           <= idx + IDXW'(1);
      end
    end
  end

  assign bus.result = result_q;

`ifdef ALU_SEQ_FLAGS_EN
  logic zero_q;
  logic carry_q;
  logic ovf_q;

  // At the final edge c still holds the carry into the MSB, so it is the
  // MSB carry-in used for signed overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (last) begin
      zero_q  <= (final_res == '0);
      carry_q <= slice_cout;
      ovf_q   <= c ^ slice_cout;
    end
  end

  assign bus.zero  = zero_q;
  assign bus.carry = carry_q;
  assign bus.ovf   = ovf_q;
`else
  assign bus.zero  = 1'b0;
  assign bus.carry = 1'b0;
  assign bus.ovf   = 1'b0;
`endif

endmodule
